// File: rtl/hvac_actuator.sv
// Actuator stage behind the hvac comparator: turns heat/cool/idle/speed commands into
// relay drive with minimum run time, fan purge, off-time lockout and a ramped PWM fan.
module hvac_actuator #(
  parameter int MIN_ON    = 8,
  parameter int MIN_OFF   = 8,
  parameter int PURGE_CYC = 4,
  parameter int RAMP_CYC  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       heat,
  input  logic       cool,
  input  logic       idle,
  input  logic [1:0] speed,
  output logic       heater_en,
  output logic       comp_en,
  output logic       fan_pwm,
  output logic [1:0] fan_level,
  output logic [2:0] state,
  output logic       err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEAT    = 3'd1;
  localparam logic [2:0] ST_COOL    = 3'd2;
  localparam logic [2:0] ST_PURGE   = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam logic [7:0] MIN_ON_LAST  = 8'(MIN_ON - 1);
  localparam logic [7:0] MIN_OFF_LAST = 8'(MIN_OFF - 1);
  localparam logic [7:0] PURGE_LAST   = 8'(PURGE_CYC - 1);
  localparam logic [7:0] RAMP_LAST    = 8'(RAMP_CYC - 1);

  logic       heat_req;
  logic       cool_req;
  logic       illegal;
  logic [2:0] next_state;
  logic [7:0] cnt;
  logic [7:0] ramp_cnt;
  logic [1:0] pwm_cnt;
  logic [1:0] fan_target;
  logic       ramp_wrap;

  // Conflicting commands yield no request at all; they only raise err.
  assign heat_req = heat & ~cool & ~idle;
  assign cool_req = cool & ~heat & ~idle;
  assign illegal  = (heat & cool) | (idle & (heat | cool));

  always_comb begin
    next_state = state;
    case (state)
      ST_LOCKOUT: if (cnt == MIN_OFF_LAST) next_state = ST_IDLE;
      ST_IDLE: begin
        if (heat_req)      next_state = ST_HEAT;
        else if (cool_req) next_state = ST_COOL;
      end
      ST_HEAT:  if (!heat_req && cnt >= MIN_ON_LAST) next_state = ST_PURGE;
      ST_COOL:  if (!cool_req && cnt >= MIN_ON_LAST) next_state = ST_PURGE;
      ST_PURGE: if (cnt == PURGE_LAST) next_state = ST_LOCKOUT;
      default:  next_state = ST_LOCKOUT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOCKOUT;
      cnt   <= 8'd0;
      err   <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) cnt <= 8'd0;
      else if (cnt != 8'hFF)   cnt <= cnt + 8'd1;
      if (illegal) err <= 1'b1;
    end
  end

  assign heater_en = (state == ST_HEAT);
  assign comp_en   = (state == ST_COOL);

  always_comb begin
    fan_target = 2'd0;
    case (state)
      ST_HEAT, ST_COOL: fan_target = (speed == 2'd0) ? 2'd1 : speed;
      ST_PURGE:         fan_target = 2'd1;
      default:          fan_target = 2'd0;
    endcase
  end

  assign ramp_wrap = (ramp_cnt == RAMP_LAST);

  // Fan level moves at most one step per ramp period toward the current target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_cnt  <= 8'd0;
      fan_level <= 2'd0;
      pwm_cnt   <= 2'd0;
      fan_pwm   <= 1'b0;
    end else begin
      ramp_cnt <= ramp_wrap ? 8'd0 : ramp_cnt + 8'd1;
      if (ramp_wrap && fan_level != fan_target) begin
        if (fan_level < fan_target) fan_level <= fan_level + 2'd1;
        else                        fan_level <= fan_level - 2'd1;
      end
      pwm_cnt <= pwm_cnt + 2'd1;
      fan_pwm <= (pwm_cnt < fan_level);
    end
  end

endmodule

// File: tb/tb_hvac_actuator.sv
// Directed bench for hvac_actuator: lockout, minimum on-time, purge, fan ramp/PWM,
// changeover, sticky error flag and asynchronous reset mid-run.
module tb_hvac_actuator;

  logic       clk;
  logic       rst_n;
  logic       heat;
  logic       cool;
  logic       idle;
  logic [1:0] speed;
  logic       heater_en;
  logic       comp_en;
  logic       fan_pwm;
  logic [1:0] fan_level;
  logic [2:0] state;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int pwm_high = 0;

  hvac_actuator #(
    .MIN_ON(8), .MIN_OFF(8), .PURGE_CYC(4), .RAMP_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .heat(heat), .cool(cool), .idle(idle), .speed(speed),
    .heater_en(heater_en), .comp_en(comp_en), .fan_pwm(fan_pwm),
    .fan_level(fan_level), .state(state), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic h, input logic c, input logic i, input logic [1:0] s);
    heat  = h;
    cool  = c;
    idle  = i;
    speed = s;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    @(negedge clk);
    edge_n++;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  // Relay outputs follow the expected state; both relays high is always an error.
  task automatic checkRelays(input logic [2:0] exp_state);
    checkOutput("state", 8'(state), 8'(exp_state));
    checkOutput("heater_en", 8'(heater_en), 8'(exp_state == 3'd1));
    checkOutput("comp_en", 8'(comp_en), 8'(exp_state == 3'd2));
    checkOutput("relay_excl", 8'(heater_en & comp_en), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);

    $display("[TB] power-up lockout with heat held, then minimum on-time and purge");
    applyReset();
    checkRelays(3'd4);
    checkOutput("rst_fan_pwm", 8'(fan_pwm), 8'd0);
    checkOutput("rst_fan_level", 8'(fan_level), 8'd0);
    checkOutput("rst_err", 8'(err), 8'd0);
    for (int n = 1; n <= 30; n++) begin
      stepEdge();
      checkRelays((n < 8) ? 3'd4 : (n == 8) ? 3'd0 : (n <= 16) ? 3'd1 :
                  (n <= 20) ? 3'd3 : (n <= 28) ? 3'd4 : 3'd0);
      checkOutput("fan_level_heat", 8'(fan_level), (n >= 12 && n < 24) ? 8'd1 : 8'd0);
      checkOutput("err_clean", 8'(err), 8'd0);
      if (n == 9) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    end

    $display("[TB] illegal command in IDLE");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);
    stepEdge();
    checkRelays(3'd0);
    checkOutput("err_set", 8'(err), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    stepEdge();
    checkRelays(3'd0);
    checkOutput("err_hold", 8'(err), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0);
    stepEdge();
    checkRelays(3'd0);
    checkOutput("err_hold2", 8'(err), 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    applyReset();
    checkOutput("err_clear", 8'(err), 8'd0);

    $display("[TB] cool with speed 3: fan ramp and PWM duty");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
    applyReset();
    pwm_high = 0;
    for (int n = 1; n <= 48; n++) begin
      stepEdge();
      checkRelays((n < 8) ? 3'd4 : (n == 8) ? 3'd0 : 3'd2);
      checkOutput("fan_level_ramp", 8'(fan_level),
                  (n < 12) ? 8'd0 : (n < 16) ? 8'd1 : (n < 20) ? 8'd2 : 8'd3);
      if (n >= 21) begin
        checkOutput("fan_pwm_l3", 8'(fan_pwm), (n % 4 != 0) ? 8'd1 : 8'd0);
        if (fan_pwm === 1'b1) pwm_high++;
      end
    end
    checkOutput("pwm_duty", 8'(pwm_high), 8'd21);

    $display("[TB] asynchronous reset while cooling at fan level 2");
    applyReset();
    for (int n = 1; n <= 17; n++) stepEdge();
    checkRelays(3'd2);
    checkOutput("pre_rst_level", 8'(fan_level), 8'd2);
    checkOutput("pre_rst_pwm", 8'(fan_pwm), 8'd1);
    rst_n = 1'b0;
    #1;
    checkRelays(3'd4);
    checkOutput("async_fan_pwm", 8'(fan_pwm), 8'd0);
    checkOutput("async_fan_level", 8'(fan_level), 8'd0);
    #1;
    rst_n = 1'b1;
    edge_n = 0;
    for (int n = 1; n <= 9; n++) begin
      stepEdge();
      checkRelays((n < 8) ? 3'd4 : (n == 8) ? 3'd0 : 3'd2);
    end

    $display("[TB] heat to cool changeover");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    applyReset();
    for (int n = 1; n <= 43; n++) begin
      stepEdge();
      checkRelays((n < 8) ? 3'd4 : (n == 8) ? 3'd0 : (n <= 28) ? 3'd1 :
                  (n <= 32) ? 3'd3 : (n <= 40) ? 3'd4 : (n == 41) ? 3'd0 : 3'd2);
      if (n == 28) applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
